// File: rtl/iagu_pkg.sv
// Shared types and default widths for the input address generation unit.
package iagu_pkg;

  localparam int unsigned IAGU_ADDR_W = 13;
  localparam int unsigned IAGU_CNT_W  = 8;
  localparam int unsigned IAGU_ITV_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } iagu_state_e;

endpackage

// File: rtl/iagu_interval_cnt.sv
// Loadable down-counter that times the GAP phase between accepted reads.
module iagu_interval_cnt #(
  parameter int unsigned ITV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ITV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [ITV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ITV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the cycle whose decrement takes the count to zero (last GAP cycle).
  assign zero = (cnt_q <= ITV_W'(1));

endmodule

// File: rtl/iagu_stride_gen.sv
// 2-D strided read address generator: walks rows x piece words of the IO buffer
// at a programmable minimum read interval, then pulses the NPE sorter.
module iagu_stride_gen
  import iagu_pkg::*;
#(
  parameter int unsigned ADDR_W = IAGU_ADDR_W,
  parameter int unsigned CNT_W  = IAGU_CNT_W,
  parameter int unsigned ITV_W  = IAGU_ITV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_start_d,
  input  logic [CNT_W-1:0]  in_piece,
  input  logic [CNT_W-1:0]  in_rows,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ITV_W-1:0]  interval,
  output logic              o_rd_en,
  input  logic              i_rd_rdy,
  output logic [ADDR_W-1:0] o_d_addr,
  output logic              o_sorter_out,
  output logic              o_busy
);

  iagu_state_e state_q, state_d;

  logic [CNT_W-1:0]  piece_q, rows_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ITV_W-1:0]  itv_q;
  logic              cfg_load;

  logic [CNT_W-1:0]  piece_cnt_q, piece_cnt_d;
  logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic rd_en_q, sorter_q, busy_q;

  logic gap_load, gap_dec, gap_zero;
  logic last_piece, last_row;

  assign last_piece = (piece_cnt_q == (piece_q - CNT_W'(1)));
  assign last_row   = (row_cnt_q == (rows_q - CNT_W'(1)));

  iagu_interval_cnt #(
    .ITV_W(ITV_W)
  ) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (gap_load),
    .load_val(itv_q - ITV_W'(1)),
    .dec     (gap_dec),
    .zero    (gap_zero)
  );

  always_comb begin
    state_d     = state_q;
    piece_cnt_d = piece_cnt_q;
    row_cnt_d   = row_cnt_q;
    addr_d      = addr_q;
    base_d      = base_q;
    cfg_load    = 1'b0;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Abort beats a simultaneous start.
        if (start_calculate && !abort) begin
          cfg_load    = 1'b1;
          piece_cnt_d = '0;
          row_cnt_d   = '0;
          addr_d      = addr_start_d;
          base_d      = addr_start_d;
          state_d     = ((in_piece == '0) || (in_rows == '0)) ? StDone : StIssue;
        end
      end

      StIssue: begin
        if (abort) begin
          state_d = StIdle;
        end else if (i_rd_rdy) begin
          if (last_piece && last_row) begin
            state_d = StDone;
          end else begin
            if (last_piece) begin
              piece_cnt_d = '0;
              row_cnt_d   = row_cnt_q + CNT_W'(1);
              base_d      = base_q + stride_q;
              addr_d      = base_q + stride_q;
            end else begin
              piece_cnt_d = piece_cnt_q + CNT_W'(1);
              addr_d      = addr_q + ADDR_W'(1);
            end
            if (itv_q != ITV_W'(1)) begin
              gap_load = 1'b1;
              state_d  = StGap;
            end
          end
        end
      end

      StGap: begin
        gap_dec = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (gap_zero) begin
          state_d = StIssue;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      piece_q     <= '0;
      rows_q      <= '0;
      stride_q    <= '0;
      itv_q       <= '0;
      piece_cnt_q <= '0;
      row_cnt_q   <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      rd_en_q     <= 1'b0;
      sorter_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      piece_cnt_q <= piece_cnt_d;
      row_cnt_q   <= row_cnt_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      if (cfg_load) begin
        piece_q  <= in_piece;
        rows_q   <= in_rows;
        stride_q <= row_stride;
        // An interval of 0 behaves as back-to-back reads.
        itv_q    <= (interval == '0) ? ITV_W'(1) : interval;
      end
      rd_en_q  <= (state_d == StIssue);
      sorter_q <= (state_d == StDone);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_d_addr     = addr_q;
  assign o_sorter_out = sorter_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_iagu_stride_gen.sv
// Bench for iagu_stride_gen: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle/address expectations.
module tb_iagu_stride_gen;

  localparam int unsigned AW = 13;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst, start_calculate, abort, i_rd_rdy;
  logic          o_rd_en, o_sorter_out, o_busy;
  logic [AW-1:0] addr_start_d, row_stride, o_d_addr;
  logic [CW-1:0] in_piece, in_rows;
  logic [IW-1:0] interval;

  iagu_stride_gen dut (
    .clk            (clk),
    .rst            (rst),
    .start_calculate(start_calculate),
    .abort          (abort),
    .addr_start_d   (addr_start_d),
    .in_piece       (in_piece),
    .in_rows        (in_rows),
    .row_stride     (row_stride),
    .interval       (interval),
    .o_rd_en        (o_rd_en),
    .i_rd_rdy       (i_rd_rdy),
    .o_d_addr       (o_d_addr),
    .o_sorter_out   (o_sorter_out),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending addresses of the walk, cycles until the next read may issue.
  bit m_active = 1'b0, m_pulse = 1'b0, m_zero = 1'b1;
  int m_wait = 0, m_itv = 1;
  int m_q[$];

  bit obs_rd = 1'b0;
  int obs_addr = 0;
  int lg_cyc[$], lg_addr[$], lg_pulse[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_p
    bit s_rst, s_start, s_abort, s_rdy, cur_rd, exp_rd;
    s_rst   = rst;
    s_start = start_calculate;
    s_abort = abort;
    s_rdy   = i_rd_rdy;
    cur_rd  = m_active && !m_pulse && (m_wait == 0) && (m_q.size() > 0);
    if (obs_rd && s_rdy) begin
      lg_cyc.push_back(cyc);
      lg_addr.push_back(obs_addr);
    end
    if (s_rst) begin
      m_active = 0; m_pulse = 0; m_wait = 0; m_zero = 1; m_q.delete();
    end else if (m_active && s_abort) begin
      m_active = 0; m_pulse = 0; m_wait = 0; m_q.delete();
    end else if (m_pulse) begin
      m_pulse = 0; m_active = 0;
    end else if (m_active) begin
      if (cur_rd && s_rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_pulse = 1;
        else m_wait = m_itv - 1;
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end else if (s_start && !s_abort) begin
      for (int r = 0; r < int'(in_rows); r++)
        for (int p = 0; p < int'(in_piece); p++)
          m_q.push_back((int'(addr_start_d) + r * int'(row_stride) + p) % 8192);
      m_itv    = (interval == 0) ? 1 : int'(interval);
      m_active = 1; m_wait = 0; m_zero = 0;
      if (m_q.size() == 0) m_pulse = 1;
    end
    cyc++;
    #1;
    exp_rd = m_active && !m_pulse && (m_wait == 0) && (m_q.size() > 0);
    chk("rd_en", int'(o_rd_en), int'(exp_rd));
    chk("busy", int'(o_busy), int'(m_active));
    chk("sorter", int'(o_sorter_out), int'(m_pulse));
    if (exp_rd) chk("addr", int'(o_d_addr), m_q[0]);
    else if (m_zero) chk("addr_rst", int'(o_d_addr), 0);
    obs_rd   = o_rd_en;
    obs_addr = int'(o_d_addr);
    if (o_sorter_out) lg_pulse.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues a start this cycle; returns its cycle index with the bench one cycle later.
  task automatic go(input int a, input int p, input int r, input int s, input int itv,
                    output int t);
    addr_start_d    = AW'(a);
    in_piece        = CW'(p);
    in_rows         = CW'(r);
    row_stride      = AW'(s);
    interval        = IW'(itv);
    start_calculate = 1'b1;
    lg_cyc.delete(); lg_addr.delete(); lg_pulse.delete();
    t = cyc;
    step();
    start_calculate = 1'b0;
    // Scramble config to show it was latched at start.
    addr_start_d = 13'h0777;
    in_piece     = 8'd9;
    in_rows      = 8'd7;
    row_stride   = 13'h0555;
    interval     = 4'd11;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((o_busy || m_active) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      total++;
      bad++;
      $display("FAIL timeout @cyc %0d: busy=%0d want 0", cyc, o_busy);
    end
  endtask

  task automatic chk_reads(input string name, input int t, input int cyc_off[$],
                           input int addrs[$]);
    chk({name, "_nreads"}, lg_cyc.size(), addrs.size());
    foreach (addrs[i]) begin
      if (i < lg_cyc.size()) begin
        chk({name, "_rdcyc"}, lg_cyc[i] - t, cyc_off[i]);
        chk({name, "_rdaddr"}, lg_addr[i], addrs[i]);
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; start_calculate = 1'b0; abort = 1'b0; i_rd_rdy = 1'b1;
    addr_start_d = '0; in_piece = '0; in_rows = '0; row_stride = '0; interval = '0;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("rst_rd_en", int'(o_rd_en), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_sorter", int'(o_sorter_out), 0);
    chk("rst_addr", int'(o_d_addr), 0);

    // Single row, interval 5.
    go(13'h010, 4, 1, 0, 5, t);
    chk("t1_first_addr", int'(o_d_addr), 'h010);
    wait_idle(60);
    chk_reads("t1", t, '{1, 6, 11, 16}, '{'h010, 'h011, 'h012, 'h013});
    chk("t1_npulse", lg_pulse.size(), 1);
    chk("t1_pulse_cyc", lg_pulse[0] - t, 17);
    chk("t1_idle_cyc", cyc - t, 18);

    // Two rows, stride 0x20, back-to-back.
    go(13'h100, 3, 2, 'h20, 1, t);
    wait_idle(40);
    chk_reads("t2", t, '{1, 2, 3, 4, 5, 6}, '{'h100, 'h101, 'h102, 'h120, 'h121, 'h122});
    chk("t2_npulse", lg_pulse.size(), 1);
    chk("t2_pulse_cyc", lg_pulse[0] - t, 7);
    chk("t2_idle_cyc", cyc - t, 8);

    // Backpressure on the second read.
    go(13'h040, 3, 1, 0, 2, t);
    for (int r = 1; r <= 12; r++) begin
      i_rd_rdy = !(r >= 3 && r <= 5);
      step();
    end
    i_rd_rdy = 1'b1;
    wait_idle(40);
    chk_reads("t3", t, '{1, 6, 8}, '{'h040, 'h041, 'h042});
    chk("t3_pulse_cyc", lg_pulse[0] - t, 9);

    // Address wrap; interval 0 acts as 1.
    go(13'h1FFE, 4, 1, 0, 0, t);
    wait_idle(40);
    chk_reads("t4", t, '{1, 2, 3, 4}, '{'h1FFE, 'h1FFF, 'h0000, 'h0001});

    // Zero-length walk: pulse only.
    go(13'h300, 0, 5, 0, 1, t);
    wait_idle(20);
    chk("t5_nreads", lg_cyc.size(), 0);
    chk("t5_npulse", lg_pulse.size(), 1);
    chk("t5_pulse_cyc", lg_pulse[0] - t, 1);

    // Start while busy is ignored.
    go(13'h200, 2, 1, 0, 3, t);
    step();
    addr_start_d = 13'h380; in_piece = 8'd5; in_rows = 8'd1; start_calculate = 1'b1;
    step();
    start_calculate = 1'b0;
    wait_idle(40);
    chk_reads("t6", t, '{1, 4}, '{'h200, 'h201});
    chk("t6_npulse", lg_pulse.size(), 1);

    // Abort together with an accept: consumed, no pulse.
    go(13'h050, 4, 1, 0, 1, t);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t7_abort_busy", int'(o_busy), 0);
    step(); step(); step();
    chk_reads("t7", t, '{1, 2}, '{'h050, 'h051});
    chk("t7_npulse", lg_pulse.size(), 0);
    // Abort and start together in idle.
    start_calculate = 1'b1; abort = 1'b1;
    step();
    start_calculate = 1'b0; abort = 1'b0;
    chk("t7_both_busy", int'(o_busy), 0);
    go(13'h060, 2, 1, 0, 1, t);
    wait_idle(20);
    chk_reads("t7b", t, '{1, 2}, '{'h060, 'h061});
    chk("t7b_npulse", lg_pulse.size(), 1);

    // Synchronous reset mid-walk.
    go(13'h0A0, 8, 1, 0, 1, t);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t8_rd_en", int'(o_rd_en), 0);
    chk("t8_busy", int'(o_busy), 0);
    chk("t8_sorter", int'(o_sorter_out), 0);
    chk("t8_addr", int'(o_d_addr), 0);
    step(); step();
    chk("t8_npulse", lg_pulse.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
